// File: rtl/router_in_port_if.sv
// Router input-port bus: groups the node-side byte handshake
// (put_in/payload_in/free_out) and the crossbar-side packet handshake
// (pkt_out/dest_out/pkt_valid/pkt_ready), plus the occupancy and
// overflow status outputs.
//   slave  : used by the router input port (receives bytes, offers packets)
//   master : used by the node/crossbar side (drives bytes, consumes packets)
interface router_in_port_if #(
  parameter int DEPTH = 4
);
  logic                       put_in;
  logic [7:0]                 payload_in;
  logic                       free_out;
  logic [31:0]                pkt_out;
  logic [3:0]                 dest_out;
  logic                       pkt_valid;
  logic                       pkt_ready;
  logic [$clog2(DEPTH):0]     occupancy;
  logic                       overflow;

  modport slave (
    input  put_in, payload_in, pkt_ready,
    output free_out, pkt_out, dest_out, pkt_valid, occupancy, overflow
  );

  modport master (
    output put_in, payload_in, pkt_ready,
    input  free_out, pkt_out, dest_out, pkt_valid, occupancy, overflow
  );
endinterface

// File: rtl/router_in_port.sv
// Router receive stage for one node-facing port. Reassembles 32-bit packets
// from four MSB-first byte transfers, stores up to DEPTH complete packets in
// a FIFO and offers the head packet with its destination ([27:24]) to the
// crossbar over a valid/ready handshake.
// Ports:
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : router_in_port_if.slave (byte input, packet output, status)
module router_in_port #(
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  router_in_port_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [31:8]     asm_q, asm_d;
  logic            overflow_q, overflow_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]   occ_q, occ_d;
  logic [31:0]     mem_q [DEPTH];

  logic            full_s;
  logic            push_s;
  logic            pop_s;

  assign full_s = (occ_q == FULL_OCC);
  assign pop_s  = (occ_q != {OW{1'b0}}) && bus.pkt_ready;

  // Packet assembly FSM next-state: space is checked only at the first byte,
  // so a packet that starts is guaranteed a slot when its 4th byte arrives.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    overflow_d = 1'b0;
    push_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.put_in) begin
          byte_cnt_d = 2'd1;
          if (!full_s) begin
            asm_d[31:24] = bus.payload_in;
            state_d      = ST_RECV;
          end else begin
            overflow_d = 1'b1;
            state_d    = ST_DROP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (bus.put_in) begin
          // Counter wraps 3 -> 0 on the final byte.
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd1: asm_d[23:16] = bus.payload_in;
            2'd2: asm_d[15:8]  = bus.payload_in;
            2'd3: begin
              push_s  = 1'b1;
              state_d = ST_IDLE;
            end
            default: begin
              byte_cnt_d = 2'd0;
              state_d    = ST_IDLE;
            end
          endcase
        end else begin
          state_d = ST_RECV;
        end
      end
      ST_DROP: begin
        if (bus.put_in) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DROP;
          end
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        byte_cnt_d = 2'd0;
      end
    endcase
  end

  // FIFO pointer / occupancy next-state; pointers wrap since DEPTH is 2^PW.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= 2'd0;
      asm_q      <= 24'd0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      occ_q      <= {OW{1'b0}};
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

  // Packet storage; contents are qualified by occupancy so need no reset.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {asm_q, bus.payload_in};
    end
  end

  assign bus.free_out  = (state_q == ST_IDLE) && !full_s;
  assign bus.pkt_out   = mem_q[rd_ptr_q];
  assign bus.dest_out  = mem_q[rd_ptr_q][27:24];
  assign bus.pkt_valid = (occ_q != {OW{1'b0}});
  assign bus.occupancy = occ_q;
  assign bus.overflow  = overflow_q;

endmodule
